// File: rtl/wb_stage_pkg.sv
// Shared widths, result-select and load-encoding constants for the writeback stage.
// Pure declarations: no latency, no backpressure.
package wb_stage_pkg;

    localparam int REG_FILE_SIZE_BITS = 5;
    localparam int DWORD_BITS         = 64;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LD  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
    localparam logic [2:0] LOAD_LWU = 3'b110;

    localparam logic [3:0] EXC_LOAD_MISALIGNED = 4'd4;
    localparam logic [3:0] EXC_ILLEGAL         = 4'd2;

endpackage

// File: rtl/load_extend.sv
// Load-data alignment and sign/zero extension from an aligned dword; combinational.
// No state, no backpressure; flags misaligned offsets and the illegal funct3 encoding.
module load_extend
    import wb_stage_pkg::*;
#(
    parameter int XLEN = DWORD_BITS
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] w_sh;

    // Bring the addressed byte lane down to bit 0 before extending.
    assign w_sh = rdata >> {offset, 3'b000};

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            LOAD_LBU: data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
            LOAD_LH: begin
                data       = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
                misaligned = offset[0];
            end
            LOAD_LHU: begin
                data       = {{(XLEN-16){1'b0}}, w_sh[15:0]};
                misaligned = offset[0];
            end
            LOAD_LW: begin
                data       = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
                misaligned = (offset[1:0] != 2'b00);
            end
            LOAD_LWU: begin
                data       = {{(XLEN-32){1'b0}}, w_sh[31:0]};
                misaligned = (offset[1:0] != 2'b00);
            end
            LOAD_LD: begin
                data       = rdata;
                misaligned = (offset != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register with result select and load extension; 1-cycle latency, all outputs flopped.
// No backpressure: hold freezes the register (exception pulse still clears), flush injects a bubble.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int REG_FILE_BITS = REG_FILE_SIZE_BITS,
    parameter int XLEN          = DWORD_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     flush,
    input  logic                     hold,
    input  logic                     in_reg_we,
    input  logic [REG_FILE_BITS-1:0] in_rd,
    input  logic [1:0]               in_wb_sel,
    input  logic [XLEN-1:0]          in_alu_result,
    input  logic [XLEN-1:0]          in_mem_rdata,
    input  logic [2:0]               in_funct3,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     rf_we,
    output logic [REG_FILE_BITS-1:0] rf_write_num,
    output logic [XLEN-1:0]          rf_input_data,
    output logic                     fwd_valid,
    output logic [REG_FILE_BITS-1:0] fwd_rd,
    output logic [XLEN-1:0]          fwd_data,
    output logic [63:0]              instret,
    output logic                     exc_valid,
    output logic [3:0]               exc_cause,
    output logic [XLEN-1:0]          exc_pc
);

    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_result;
    logic            w_misaligned;
    logic            w_illegal;
    logic            w_exc;
    logic            w_wr;
    logic [3:0]      w_cause;

    logic                     r_we;
    logic [REG_FILE_BITS-1:0] r_num;
    logic [XLEN-1:0]          r_data;
    logic [63:0]              r_instret;
    logic                     r_exc_vld;
    logic [3:0]               r_exc_cause;
    logic [XLEN-1:0]          r_exc_pc;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata      (in_mem_rdata),
        .offset     (in_alu_result[2:0]),
        .funct3     (in_funct3),
        .data       (w_load_data),
        .misaligned (w_misaligned),
        .illegal    (w_illegal)
    );

    always_comb begin
        w_result = in_alu_result;
        case (wb_sel_e'(in_wb_sel))
            WB_SEL_MEM: w_result = w_load_data;
            WB_SEL_PC4: w_result = in_pc + XLEN'(4);
            default:    w_result = in_alu_result;
        endcase
    end

    // Faults only matter when the load result is actually selected.
    assign w_exc   = (wb_sel_e'(in_wb_sel) == WB_SEL_MEM) & (w_misaligned | w_illegal);
    assign w_cause = w_illegal ? EXC_ILLEGAL : EXC_LOAD_MISALIGNED;
    assign w_wr    = in_reg_we & (in_rd != '0) & ~w_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_num       <= '0;
            r_data      <= '0;
            r_instret   <= '0;
            r_exc_vld   <= 1'b0;
            r_exc_cause <= '0;
            r_exc_pc    <= '0;
        end else if (flush || (!hold && !in_valid)) begin
            r_we        <= 1'b0;
            r_num       <= '0;
            r_data      <= '0;
            r_exc_vld   <= 1'b0;
            r_exc_cause <= '0;
            r_exc_pc    <= '0;
        end else if (hold) begin
            r_exc_vld   <= 1'b0;
            r_exc_cause <= '0;
            r_exc_pc    <= '0;
        end else begin
            r_we        <= w_wr;
            r_num       <= in_rd;
            r_data      <= w_result;
            r_exc_vld   <= w_exc;
            r_exc_cause <= w_exc ? w_cause : 4'd0;
            r_exc_pc    <= w_exc ? in_pc : '0;
            if (!w_exc) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign rf_we         = r_we;
    assign rf_write_num  = r_num;
    assign rf_input_data = r_data;
    assign fwd_valid     = r_we;
    assign fwd_rd        = r_num;
    assign fwd_data      = r_data;
    assign instret       = r_instret;
    assign exc_valid     = r_exc_vld;
    assign exc_cause     = r_exc_cause;
    assign exc_pc        = r_exc_pc;

endmodule

// File: tb/tb_wb_stage.sv
// Directed-vector bench for wb_stage: driver pushes hand-computed expectations,
// a monitor pops one per posedge and compares.
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic        hold;
    logic        in_reg_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_rdata;
    logic [2:0]  in_funct3;
    logic [63:0] in_pc;
    logic        rf_we;
    logic [4:0]  rf_write_num;
    logic [63:0] rf_input_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [63:0] instret;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [63:0] exc_pc;

    wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .flush         (flush),
        .hold          (hold),
        .in_reg_we     (in_reg_we),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_mem_rdata  (in_mem_rdata),
        .in_funct3     (in_funct3),
        .in_pc         (in_pc),
        .rf_we         (rf_we),
        .rf_write_num  (rf_write_num),
        .rf_input_data (rf_input_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .instret       (instret),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc)
    );

    typedef struct {
        int          id;
        logic        full;
        logic        we;
        logic [4:0]  num;
        logic [63:0] data;
        logic [63:0] ir;
        logic        exc;
        logic [3:0]  cause;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id   = 0;

    localparam logic [63:0] RD = 64'h8877_6655_4433_2281;
    localparam logic [1:0]  A  = 2'd0;
    localparam logic [1:0]  M  = 2'd1;
    localparam logic [1:0]  P  = 2'd2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", nm, id, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rf_we"}, -1, rf_we, 0);
        chk({tag, "_rf_num"}, -1, rf_write_num, 0);
        chk({tag, "_rf_data"}, -1, rf_input_data, 0);
        chk({tag, "_fwd_valid"}, -1, fwd_valid, 0);
        chk({tag, "_instret"}, -1, instret, 0);
        chk({tag, "_exc_valid"}, -1, exc_valid, 0);
        chk({tag, "_exc_pc"}, -1, exc_pc, 0);
    endtask

    task automatic step(input logic v, fl, hd, we, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [63:0] alu, rdat, input logic [2:0] f3, input logic [63:0] pc,
                        input logic full, e_we, input logic [4:0] e_num, input logic [63:0] e_data, e_ir,
                        input logic e_exc, input logic [3:0] e_cause, input logic [63:0] e_pc);
        exp_t e;
        @(negedge clk);
        in_valid = v; flush = fl; hold = hd; in_reg_we = we; in_rd = rd; in_wb_sel = sel;
        in_alu_result = alu; in_mem_rdata = rdat; in_funct3 = f3; in_pc = pc;
        vec_id++;
        e.id = vec_id; e.full = full; e.we = e_we; e.num = e_num; e.data = e_data; e.ir = e_ir;
        e.exc = e_exc; e.cause = e_cause; e.pc = e_pc;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; hold = 0; in_reg_we = 0; in_rd = 0; in_wb_sel = 0;
        in_alu_result = 0; in_mem_rdata = 0; in_funct3 = 0; in_pc = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rf_we", e.id, rf_we, e.we);
                chk("fwd_valid", e.id, fwd_valid, e.we);
                chk("instret", e.id, instret, e.ir);
                chk("exc_valid", e.id, exc_valid, e.exc);
                if (e.full || e.we) begin
                    chk("rf_write_num", e.id, rf_write_num, e.num);
                    chk("rf_input_data", e.id, rf_input_data, e.data);
                    chk("fwd_rd", e.id, fwd_rd, e.num);
                    chk("fwd_data", e.id, fwd_data, e.data);
                end
                if (e.full || e.exc) begin
                    chk("exc_cause", e.id, exc_cause, e.cause);
                    chk("exc_pc", e.id, exc_pc, e.pc);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        //   v fl hd we rd  sel alu                    rdata f3      pc                      full we num data                    ir  exc cause pc
        step(1, 0, 0, 1, 5, A, 64'h1234,               RD, 3'b000, 64'h0,                  1, 1, 5, 64'h1234,                1, 0, 0, 0);
        step(1, 0, 0, 1, 6, M, 64'h2000,               RD, 3'b000, 64'h10,                 1, 1, 6, 64'hFFFF_FFFF_FFFF_FF81, 2, 0, 0, 0);
        step(1, 0, 0, 1, 7, M, 64'h2007,               RD, 3'b100, 64'h14,                 1, 1, 7, 64'h88,                  3, 0, 0, 0);
        step(1, 0, 0, 1, 8, M, 64'h2006,               RD, 3'b001, 64'h18,                 1, 1, 8, 64'hFFFF_FFFF_FFFF_8877, 4, 0, 0, 0);
        step(1, 0, 0, 1, 9, M, 64'h2004,               RD, 3'b110, 64'h1C,                 1, 1, 9, 64'h8877_6655,           5, 0, 0, 0);
        step(1, 0, 0, 1, 10, M, 64'h2008,              RD, 3'b011, 64'h20,                 1, 1, 10, RD,                     6, 0, 0, 0);
        step(1, 0, 0, 1, 11, M, 64'h1002,              RD, 3'b010, 64'h400,                0, 0, 0, 0,                       6, 1, 4, 64'h400);
        step(0, 0, 0, 0, 0, A, 64'h0,                  RD, 3'b000, 64'h0,                  1, 0, 0, 0,                       6, 0, 0, 0);
        step(1, 0, 0, 1, 12, M, 64'h3000,              RD, 3'b111, 64'h500,                0, 0, 0, 0,                       6, 1, 2, 64'h500);
        step(1, 0, 0, 1, 0, A, 64'h55,                 RD, 3'b000, 64'h24,                 0, 0, 0, 0,                       7, 0, 0, 0);
        step(1, 0, 0, 1, 1, P, 64'h0,                  RD, 3'b000, 64'h100,                1, 1, 1, 64'h104,                 8, 0, 0, 0);
        step(1, 0, 0, 1, 2, P, 64'h0,                  RD, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 2, 64'h0,                  9, 0, 0, 0);
        step(1, 1, 0, 1, 3, A, 64'h77,                 RD, 3'b000, 64'h28,                 1, 0, 0, 0,                       9, 0, 0, 0);
        step(1, 0, 0, 1, 4, A, 64'hABCD,               RD, 3'b000, 64'h2C,                 1, 1, 4, 64'hABCD,                10, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 1, 13, A, 64'hDEAD,          RD, 3'b000, 64'h30,                 1, 1, 4, 64'hABCD,                10, 0, 0, 0);
        step(0, 0, 0, 0, 0, A, 64'h0,                  RD, 3'b000, 64'h0,                  1, 0, 0, 0,                       10, 0, 0, 0);
        step(1, 0, 0, 1, 14, 2'd3, 64'h99,             RD, 3'b000, 64'h34,                 1, 1, 14, 64'h99,                 11, 0, 0, 0);
        step(1, 0, 0, 1, 15, A, 64'h42,                RD, 3'b000, 64'h38,                 1, 1, 15, 64'h42,                 12, 0, 0, 0);
        step(1, 1, 1, 1, 16, A, 64'h1,                 RD, 3'b000, 64'h3C,                 1, 0, 0, 0,                       12, 0, 0, 0);
        step(1, 0, 0, 1, 16, A, 64'h31,                RD, 3'b000, 64'h40,                 1, 1, 16, 64'h31,                 13, 0, 0, 0);

        // Async reset mid-cycle while a write is being presented.
        @(posedge clk);
        #3;
        chk("pre_reset_rf_we", -1, rf_we, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        idle_inputs();
        rst_n = 1'b1;

        step(1, 0, 0, 1, 17, A, 64'h61,                RD, 3'b000, 64'h44,                 1, 1, 17, 64'h61,                 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, A, 64'h0,                  RD, 3'b000, 64'h0,                  1, 0, 0, 0,                       1, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
